// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the 16-bit pipelined CPU
package cpu_pkg;

  localparam int          WORD_W    = 16;
  localparam logic [15:0] PC_STEP   = 16'h0002;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [3:0]  HALT_OPC  = 4'hF;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // PC register update select
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_op_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter plus pending-redirect target register
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int                WORD_W   = cpu_pkg::WORD_W,
  parameter logic [WORD_W-1:0] PC_STEP  = cpu_pkg::PC_STEP,
  parameter logic [WORD_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  pc_op_t            pc_op_i,
  input  logic [WORD_W-1:0] load_pc_i,
  input  logic              pend_we_i,
  input  logic [WORD_W-1:0] pend_pc_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] pend_pc_o,
  output logic [WORD_W-1:0] inc_pc_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] pend_q;
  logic [WORD_W-1:0] pend_d;

  // Incremented PC wraps naturally at the top of the address space
  assign inc_pc_o = pc_q + PC_STEP;

  // Next-state select for PC and pending target
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    case (pc_op_i)
      PC_LOAD: pc_d = load_pc_i;
      PC_INC:  pc_d = inc_pc_o;
      default: pc_d = pc_q;
    endcase
    if (pend_we_i) begin
      pend_d = pend_pc_i;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

  assign pc_o      = pc_q;
  assign pend_pc_o = pend_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage driving IF/ID and a ready-handshaked imem port
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                WORD_W   = cpu_pkg::WORD_W,
  parameter logic [WORD_W-1:0] PC_STEP  = cpu_pkg::PC_STEP,
  parameter logic [WORD_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [3:0]        HALT_OPC = cpu_pkg::HALT_OPC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_rdy,
  output logic [WORD_W-1:0] inc_PC_out,
  output logic [WORD_W-1:0] instr_out,
  output logic              instr_vld,
  output logic              halted
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  pc_op_t            pc_op;
  logic [WORD_W-1:0] load_pc;
  logic              pend_we;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pend_pc;
  logic              accept;

  fetch_pc_reg #(
    .WORD_W   (WORD_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .pc_op_i   (pc_op),
    .load_pc_i (load_pc),
    .pend_we_i (pend_we),
    .pend_pc_i (redirect_pc),
    .pc_o      (pc),
    .pend_pc_o (pend_pc),
    .inc_pc_o  (inc_PC_out)
  );

  // A fetch is consumed by IF/ID only when nothing upstream wants it dropped
  assign accept = (state_q == FETCH) && imem_rdy && !stall && !redirect;

  // Request stays up in DRAIN so the in-flight access can complete and be discarded
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = pc;
  assign instr_vld = accept;
  assign instr_out = accept ? imem_rdata : WORD_W'(NOP_INSTR);
  assign halted    = (state_q == HALT);

  // Fetch sequencer: next state and PC update select
  always_comb begin
    state_d = state_q;
    pc_op   = PC_HOLD;
    load_pc = redirect_pc;
    pend_we = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_op = PC_LOAD;
        end
      end
      FETCH: begin
        if (redirect && imem_rdy) begin
          pc_op = PC_LOAD;
        end else if (redirect) begin
          // Address must stay put until the memory finishes; remember target
          pend_we = 1'b1;
          state_d = DRAIN;
        end else if (stall) begin
          pc_op = PC_HOLD;
        end else if (imem_rdy) begin
          if (imem_rdata[WORD_W-1 -: 4] == HALT_OPC) begin
            state_d = HALT;
          end else begin
            pc_op = PC_INC;
          end
        end
      end
      DRAIN: begin
        if (imem_rdy) begin
          pc_op   = PC_LOAD;
          load_pc = redirect ? redirect_pc : pend_pc;
          state_d = FETCH;
        end else if (redirect) begin
          pend_we = 1'b1;
        end
      end
      HALT: begin
        if (redirect) begin
          pc_op   = PC_LOAD;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_rdy;
  logic [15:0] inc_PC_out;
  logic [15:0] instr_out;
  logic        instr_vld;
  logic        halted;

  int checks;
  int failures;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rdy    (imem_rdy),
    .inc_PC_out  (inc_PC_out),
    .instr_out   (instr_out),
    .instr_vld   (instr_vld),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at 0x0010 is a HALT, everything else is its low 12 address bits
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hF123;
    return {4'h0, a[11:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=waking, 1=fetching, 2=discarding, 3=stopped
  int          m_mode;
  logic [15:0] m_pc;
  logic [15:0] m_pend;
  logic        m_valid;
  logic        m_acc;
  logic        seen_0300;

  initial begin
    m_valid   = 1'b0;
    m_mode    = 0;
    m_pc      = 16'h0000;
    m_pend    = 16'h0000;
    seen_0300 = 1'b0;
  end

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    if (imem_req === 1'b1 && imem_addr === 16'h0300) seen_0300 <= 1'b1;
    m_acc = (m_mode == 1) && imem_rdy && !stall && !redirect;
    if (m_valid) begin
      chk("m_req", {15'd0, imem_req}, {15'd0, (m_mode == 1) || (m_mode == 2)});
      if (m_mode == 1 || m_mode == 2) chk("m_addr", imem_addr, m_pc);
      chk("m_inc", inc_PC_out, m_pc + 16'h0002);
      chk("m_vld", {15'd0, instr_vld}, {15'd0, m_acc});
      chk("m_instr", instr_out, m_acc ? mem_word(m_pc) : 16'h0000);
      chk("m_halted", {15'd0, halted}, {15'd0, m_mode == 3});
    end
    if (rst) begin
      m_valid <= 1'b1;
      m_mode  <= 0;
      m_pc    <= 16'h0000;
      m_pend  <= 16'h0000;
    end else if (m_valid) begin
      if (m_mode == 0) begin
        m_mode <= 1;
        if (redirect) m_pc <= redirect_pc;
      end else if (m_mode == 1) begin
        if (redirect && imem_rdy) m_pc <= redirect_pc;
        else if (redirect) begin
          m_pend <= redirect_pc;
          m_mode <= 2;
        end else if (!stall && imem_rdy) begin
          if (mem_word(m_pc) >= 16'hF000) m_mode <= 3;
          else m_pc <= m_pc + 16'h0002;
        end
      end else if (m_mode == 2) begin
        if (imem_rdy) begin
          m_pc   <= redirect ? redirect_pc : m_pend;
          m_mode <= 1;
        end else if (redirect) m_pend <= redirect_pc;
      end else begin
        if (redirect) begin
          m_pc   <= redirect_pc;
          m_mode <= 1;
        end
      end
    end
  end

  // One cycle of stimulus; returns at the following negedge for sampling
  task automatic drive(input logic r, input logic st, input logic rd,
                       input logic [15:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst         = r;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdy    = rdy;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_rdy    = 1'b1;

    // 1: reset, then streaming fetch with rdy tied high
    drive(1, 0, 0, 16'h0000, 1);
    drive(1, 0, 0, 16'h0000, 1);
    drive(0, 0, 0, 16'h0000, 1);
    chk("rst_req", {15'd0, imem_req}, 16'h0000);
    chk("rst_vld", {15'd0, instr_vld}, 16'h0000);
    chk("rst_instr", instr_out, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    chk("rst_inc", inc_PC_out, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 16'h0000, 1);
      chk("t1_addr", imem_addr, 16'(2 * i));
      chk("t1_vld", {15'd0, instr_vld}, 16'h0001);
      chk("t1_inc", inc_PC_out, 16'(2 * i + 2));
    end

    // 2: redirect to 0004, then two wait-state cycles
    drive(0, 0, 1, 16'h0004, 1);
    chk("t2_redir_vld", {15'd0, instr_vld}, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 16'h0000, 0);
      chk("t2_wait_req", {15'd0, imem_req}, 16'h0001);
      chk("t2_wait_addr", imem_addr, 16'h0004);
      chk("t2_wait_vld", {15'd0, instr_vld}, 16'h0000);
      chk("t2_wait_instr", instr_out, 16'h0000);
    end
    drive(0, 0, 0, 16'h0000, 1);
    chk("t2_rdy_vld", {15'd0, instr_vld}, 16'h0001);
    chk("t2_rdy_instr", instr_out, 16'h0004);
    drive(0, 0, 0, 16'h0000, 1);
    chk("t2_next_addr", imem_addr, 16'h0006);

    // 3: stall for two cycles at 0008 with rdy high
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 16'h0000, 1);
      chk("t3_stall_vld", {15'd0, instr_vld}, 16'h0000);
      chk("t3_stall_addr", imem_addr, 16'h0008);
    end
    drive(0, 0, 0, 16'h0000, 1);
    chk("t3_acc_vld", {15'd0, instr_vld}, 16'h0001);
    chk("t3_acc_addr", imem_addr, 16'h0008);

    // 4: redirect while memory busy, re-redirect inside DRAIN
    drive(0, 0, 1, 16'h0100, 0);
    chk("t4_addr", imem_addr, 16'h000A);
    drive(0, 0, 1, 16'h0200, 0);
    chk("t4_drain_addr", imem_addr, 16'h000A);
    chk("t4_drain_req", {15'd0, imem_req}, 16'h0001);
    drive(0, 0, 0, 16'h0000, 0);
    chk("t4_drain_vld", {15'd0, instr_vld}, 16'h0000);
    drive(0, 1, 0, 16'h0000, 1);
    chk("t4_drain_rdy_vld", {15'd0, instr_vld}, 16'h0000);
    chk("t4_drain_rdy_addr", imem_addr, 16'h000A);
    drive(0, 0, 1, 16'h0010, 1);
    chk("t4_new_addr", imem_addr, 16'h0200);

    // 5: HALT fetched at 0010, wrong-path redirect releases it
    drive(0, 0, 0, 16'h0000, 1);
    chk("t5_vld", {15'd0, instr_vld}, 16'h0001);
    chk("t5_instr", instr_out, 16'hF123);
    chk("t5_inc", inc_PC_out, 16'h0012);
    for (int i = 0; i < 2; i++) begin
      drive(0, i[0], 0, 16'h0000, 1);
      chk("t5_halted", {15'd0, halted}, 16'h0001);
      chk("t5_req", {15'd0, imem_req}, 16'h0000);
      chk("t5_inc_held", inc_PC_out, 16'h0012);
    end
    drive(0, 0, 1, 16'h0040, 1);
    drive(0, 0, 0, 16'h0000, 0);
    chk("t5_unhalt", {15'd0, halted}, 16'h0000);
    chk("t5_addr", imem_addr, 16'h0040);

    // 6: reset while draining toward 0300
    drive(0, 0, 1, 16'h0300, 0);
    drive(1, 0, 0, 16'h0000, 0);
    chk("t6_drain_addr", imem_addr, 16'h0040);
    drive(0, 0, 0, 16'h0000, 1);
    chk("t6_req", {15'd0, imem_req}, 16'h0000);
    drive(0, 0, 0, 16'h0000, 1);
    chk("t6_addr0", imem_addr, 16'h0000);
    drive(0, 0, 0, 16'h0000, 1);
    chk("t6_addr1", imem_addr, 16'h0002);

    // Redirect presented in the wake-up cycle
    drive(1, 0, 0, 16'h0000, 1);
    drive(0, 0, 1, 16'h0080, 1);
    chk("idle_req", {15'd0, imem_req}, 16'h0000);
    drive(0, 0, 0, 16'h0000, 1);
    chk("idle_redir_addr", imem_addr, 16'h0080);

    // PC wrap at the top of the address space
    drive(0, 0, 1, 16'hFFFE, 1);
    drive(0, 0, 0, 16'h0000, 1);
    chk("wrap_addr", imem_addr, 16'hFFFE);
    chk("wrap_inc", inc_PC_out, 16'h0000);
    chk("wrap_instr", instr_out, 16'h0FFE);
    drive(0, 0, 0, 16'h0000, 1);
    chk("wrap_next", imem_addr, 16'h0000);
    chk("wrap_next_inc", inc_PC_out, 16'h0002);

    drive(0, 0, 0, 16'h0000, 1);
    chk("never_0300", {15'd0, seen_0300}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
